jtframe_fir_arb: RTL and testbench

Round-robin scheduler that time-shares one mono FIR engine (coefficient/sample dual-port RAM plus serial MAC) between up to four audio channels. Each channel delivers samples with a one-cycle strobe. The block latches one pending sample per channel, hands channels to the engine one at a time, and returns each filtered result to that channel's output register. It also gates coefficient writes so the coefficient RAM is only modified while the engine is idle. It sits between the sound-chip mixers and the shared FIR instance.

---
 rtl/jtframe_fir_arb.sv | 175 +++++++++++++++++
 tb/tb_jtframe_fir_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_fir_arb.sv
// jtframe_fir_arb
// Round-robin scheduler that shares one mono FIR engine between NCH audio
// channels. Each channel keeps one pending sample. Channels are handed to the
// engine one at a time, and each result goes back to that channel's output
// register. Coefficient writes are only forwarded while the engine is idle.
//
// Optional feature: define JTFRAME_FIR_TIMEOUT_EN to add an engine watchdog
// (TMAX cycles) that raises the sticky err flag and abandons the stuck run.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   sample[NCH]           per-channel new-sample strobe
//   din[NCH*16]           per-channel signed input, channel k at [16k+15:16k]
//   dout[NCH*16]          per-channel filtered output, held between updates
//   dout_stb[NCH]         one-cycle pulse when dout of that channel updates
//   overrun[NCH]          sticky, a pending sample was replaced before use
//   coef_we/addr/data     coefficient write request
//   coef_ready            write accepted this cycle (engine idle)
//   eng_start, eng_din    start pulse and sample to the engine
//   eng_cwe/caddr/cdata   coefficient write to the engine
//   eng_done, eng_dout    engine completion pulse and result
//   err                   sticky watchdog flag (0 without the macro)
module jtframe_fir_arb #(
  parameter int          NCH  = 2,
  parameter logic [15:0] TMAX = 16'd1023
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   sample,
  input  logic [NCH*16-1:0] din,
  output logic [NCH*16-1:0] dout,
  output logic [NCH-1:0]   dout_stb,
  output logic [NCH-1:0]   overrun,
  input  logic             coef_we,
  input  logic [7:0]       coef_addr,
  input  logic [15:0]      coef_data,
  output logic             coef_ready,
  output logic             eng_start,
  output logic [15:0]      eng_din,
  output logic             eng_cwe,
  output logic [7:0]       eng_caddr,
  output logic [15:0]      eng_cdata,
  input  logic             eng_done,
  input  logic [15:0]      eng_dout,
  output logic             err
);

  typedef enum logic { IDLE, BUSY } state_t;

  state_t                st;
  logic [NCH-1:0]        pend;
  logic [NCH-1:0][15:0]  pend_data;
  logic [NCH-1:0][15:0]  dout_r;
  logic [1:0]            rr, cur, cur_nxt, gnt;
  logic                  gnt_any, grant;
  logic [15:0]           gnt_data;

  assign dout       = dout_r;
  assign coef_ready = (st == IDLE);
  assign cur_nxt    = (cur == 2'(NCH-1)) ? 2'd0 : cur + 2'd1;

  // First pending channel at or after rr, wrapping. Offsets are walked from
  // the farthest down to the nearest so the nearest match is the last write.
  // All indices are loop constants, so this unrolls into a small mux tree.
  always_comb begin
    gnt_any  = 1'b0;
    gnt      = 2'd0;
    gnt_data = 16'd0;
    for (int i = NCH-1; i >= 0; i--) begin
      for (int k = 0; k < NCH; k++) begin
        if (pend[k] && rr == 2'((k - i + NCH) % NCH)) begin
          gnt_any  = 1'b1;
          gnt      = 2'(k);
          gnt_data = pend_data[k];
        end
      end
    end
  end

  // Coefficient writes take the idle slot ahead of any sample grant
  assign grant = (st == IDLE) && !coef_we && gnt_any;

  // Pending latch. A sample arriving on its own grant cycle re-arms pend
  // with the new value and is not counted as an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_data <= '0;
      overrun   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (sample[k]) begin
          pend_data[k] <= din[16*k +: 16];
          pend[k]      <= 1'b1;
          if (pend[k] && !(grant && gnt == 2'(k))) overrun[k] <= 1'b1;
        end else if (grant && gnt == 2'(k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

`ifdef JTFRAME_FIR_TIMEOUT_EN
  logic [15:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      rr        <= 2'd0;
      cur       <= 2'd0;
      dout_r    <= '0;
      dout_stb  <= '0;
      eng_start <= 1'b0;
      eng_din   <= 16'd0;
      eng_cwe   <= 1'b0;
      eng_caddr <= 8'd0;
      eng_cdata <= 16'd0;
`ifdef JTFRAME_FIR_TIMEOUT_EN
      wd_cnt    <= 16'd0;
      err       <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      eng_cwe   <= 1'b0;
      dout_stb  <= '0;
      case (st)
        IDLE: begin
          // eng_done here is a stray pulse and is dropped
          if (coef_we) begin
            eng_cwe   <= 1'b1;
            eng_caddr <= coef_addr;
            eng_cdata <= coef_data;
          end else if (grant) begin
            eng_start <= 1'b1;
            eng_din   <= gnt_data;
            cur       <= gnt;
            st        <= BUSY;
`ifdef JTFRAME_FIR_TIMEOUT_EN
            wd_cnt    <= 16'd0;
`endif
          end
        end
        BUSY: begin
          if (eng_done) begin
            for (int k = 0; k < NCH; k++) begin
              if (cur == 2'(k)) begin
                dout_r[k]   <= eng_dout;
                dout_stb[k] <= 1'b1;
              end
            end
            rr <= cur_nxt;
            st <= IDLE;
          end
`ifdef JTFRAME_FIR_TIMEOUT_EN
          // wd_cnt+1 equals the cycles elapsed since eng_start was visible
          else if (wd_cnt + 16'd1 >= TMAX) begin
            err <= 1'b1;
            rr  <= cur_nxt;
            st  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifndef JTFRAME_FIR_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_fir_arb.sv
module tb_jtframe_fir_arb;

  localparam int LAT = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sample = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [1:0]  dout_stb, overrun;
  logic        coef_we = 1'b0;
  logic [7:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_ready, eng_start, eng_cwe, err;
  logic [15:0] eng_din, eng_cdata;
  logic [7:0]  eng_caddr;
  logic        eng_done = 1'b0;
  logic [15:0] eng_dout = '0;

  jtframe_fir_arb #(.NCH(2)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .din(din), .dout(dout),
    .dout_stb(dout_stb), .overrun(overrun), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready),
    .eng_start(eng_start), .eng_din(eng_din), .eng_cwe(eng_cwe),
    .eng_caddr(eng_caddr), .eng_cdata(eng_cdata), .eng_done(eng_done),
    .eng_dout(eng_dout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [15:0] val; } exp_t;
  exp_t sq[$];   // expected engine starts, in grant order
  exp_t oq[$];   // expected output strobes

  int          checks = 0, errs = 0;
  int          eng_cnt = 0, cwe_cnt = 0;
  int          stb_cnt[2] = '{0, 0};
  logic [15:0] eng_res = '0;

  // engine model transfer function
  function automatic logic [15:0] fir(input logic [15:0] x);
    return x - 16'h0778;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] v);
    exp_t e;
    e.ch = ch; e.val = v;
    sq.push_back(e);
  endtask

  // one clock: strobes last one edge, outputs sampled 1 time unit later,
  // then the engine model advances
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    sample   = '0;
    eng_done = 1'b0;
    if (eng_start) begin
      if (sq.size() == 0) chk("start_unexp", 32'(eng_start), 32'd0);
      else begin
        e = sq.pop_front();
        chk("eng_din", 32'(eng_din), 32'(e.val));
        e.val = fir(e.val);
        oq.push_back(e);
        eng_cnt = LAT;
        eng_res = fir(eng_din);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (dout_stb[k]) begin
        stb_cnt[k]++;
        if (oq.size() == 0) chk("stb_unexp", 32'(dout_stb[k]), 32'd0);
        else begin
          e = oq.pop_front();
          chk("stb_ch", k, e.ch);
          chk("dout", 32'(dout[16*k +: 16]), 32'(e.val));
        end
      end
    end
    if (eng_cwe) cwe_cnt++;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_dout = eng_res;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sq.size() != 0 || oq.size() != 0 || eng_cnt != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(sq.size() + oq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    sq.delete(); oq.delete();
    eng_cnt = 0;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [15:0] v0, input logic [15:0] v1);
    sample = m;
    din    = {v1, v0};
    tick();
  endtask

  initial begin
    int n;
    // reset state
    do_reset();
    chk("rst_dout", dout, 32'd0);
    chk("rst_flags", {24'd0, dout_stb, overrun, eng_start, eng_cwe, err, coef_ready}, 32'd1);
    chk("rst_eng", {eng_din, eng_cdata}, 32'd0);
    chk("rst_caddr", 32'(eng_caddr), 32'd0);

    // single channel, earliest start one edge after the pend edge
    push(0, 16'h1234);
    strobe(2'b01, 16'h1234, 16'h0);
    tick();
    chk("start_lat", 32'(eng_start), 32'd1);
    drain(300);
    chk("single_dout", dout, {16'h0000, 16'h0ABC});
    chk("single_stb0", stb_cnt[0], 1);
    chk("single_stb1", stb_cnt[1], 0);

    // round robin
    do_reset();
    push(0, 16'h00A0); push(1, 16'h00B0);
    strobe(2'b11, 16'h00A0, 16'h00B0);
    drain(400);
    push(0, 16'h00C0); push(1, 16'h00D0);
    strobe(2'b11, 16'h00C0, 16'h00D0);
    drain(400);
    push(0, 16'h00E0);
    strobe(2'b01, 16'h00E0, 16'h0);
    drain(300);
    // rr now points at ch1, which goes first
    push(1, 16'h00F1); push(0, 16'h00F0);
    strobe(2'b11, 16'h00F0, 16'h00F1);
    drain(400);
    chk("rr_overrun", 32'(overrun), 32'd0);

    // overrun: second ch1 sample replaces the first while ch0 is busy
    push(0, 16'h0100); push(1, 16'h0007);
    strobe(2'b01, 16'h0100, 16'h0);
    tick();
    strobe(2'b10, 16'h0, 16'h0005);
    tick(); tick(); tick();
    chk("ovr_pre", 32'(overrun), 32'd0);
    strobe(2'b10, 16'h0, 16'h0007);
    chk("ovr_set", 32'(overrun), 32'd2);
    drain(400);

    // coefficient gating
    push(0, 16'h0200); push(1, 16'h0300);
    strobe(2'b01, 16'h0200, 16'h0);
    tick();
    cwe_cnt   = 0;
    coef_we   = 1'b1;
    coef_addr = 8'h10;
    coef_data = 16'hFFFE;
    strobe(2'b10, 16'h0, 16'h0300);
    chk("cready_busy", 32'(coef_ready), 32'd0);
    n = 0;
    while (!coef_ready && n < 200) begin
      tick();
      n++;
    end
    chk("cwe_busy", cwe_cnt, 0);
    tick();
    coef_we = 1'b0;
    chk("cwe_fwd", 32'(eng_cwe), 32'd1);
    chk("cwe_addr", 32'(eng_caddr), 32'h10);
    chk("cwe_data", 32'(eng_cdata), 32'hFFFE);
    chk("cwe_nogrant", 32'(eng_start), 32'd0);
    drain(400);
    chk("cwe_cnt", cwe_cnt, 1);

    // reset in the middle of an engine run, then a late eng_done
    push(0, 16'h0400);
    strobe(2'b01, 16'h0400, 16'h0);
    tick(); tick(); tick();
    do_reset();
    stb_cnt[0] = 0; stb_cnt[1] = 0;
    eng_dout = 16'h5555;
    eng_done = 1'b1;
    tick();
    tick(); tick();
    chk("mid_stb", stb_cnt[0] + stb_cnt[1], 0);
    chk("mid_dout", dout, 32'd0);
    chk("mid_flags", {26'd0, dout_stb, overrun, eng_start, eng_cwe}, 32'd0);
    chk("mid_eng", {eng_din, eng_cdata}, 32'd0);
    chk("mid_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
